inst_fetch_queue: RTL and testbench

INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

---
 rtl/inst_fetch_queue.sv | 118 +++++++++++
 tb/tb_inst_fetch_queue.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - instruction fetch unit with a 2-entry {pc, word} queue
module inst_fetch_queue #(
  parameter int WORD_SIZE = 16,
  parameter int DEPTH     = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  output logic                 readM1,
  output logic [WORD_SIZE-1:0] address1,
  input  logic [WORD_SIZE-1:0] data1,
  input  logic                 mem_ready,
  input  logic                 redirect,
  input  logic [WORD_SIZE-1:0] redirect_pc,
  input  logic                 halt,
  input  logic                 id_stall,
  output logic                 inst_valid,
  output logic [WORD_SIZE-1:0] inst,
  output logic [WORD_SIZE-1:0] inst_pc,
  output logic [WORD_SIZE-1:0] fetch_count
);

  typedef enum logic [1:0] {IDLE, FETCH, FULL, HALT} state_t;

  localparam logic [1:0] QCAP = 2'(DEPTH);

  state_t               state;
  state_t               state_nxt;
  logic [WORD_SIZE-1:0] fpc;
  logic [1:0]           count;
  logic [1:0]           count_nxt;
  logic                 rd_ptr;
  logic                 wr_ptr;
  logic [WORD_SIZE-1:0] pc_mem   [2];
  logic [WORD_SIZE-1:0] word_mem [2];
  logic                 accept;
  logic                 pop;

  // A redirect kills any same-cycle response: it belongs to the old stream.
  assign accept     = readM1 && mem_ready && (count != QCAP) && !redirect;
  assign pop        = inst_valid && !id_stall;
  assign inst_valid = (count != 2'd0);
  assign inst       = inst_valid ? word_mem[rd_ptr] : '0;
  assign inst_pc    = inst_valid ? pc_mem[rd_ptr] : '0;
  assign address1   = fpc;

  always_comb begin
    count_nxt = count;
    if (redirect) begin
      count_nxt = 2'd0;
    end else begin
      case ({accept, pop})
        2'b10:   count_nxt = count + 2'd1;
        2'b01:   count_nxt = count - 2'd1;
        default: count_nxt = count;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  state_nxt = FETCH;
      FETCH: begin
        if (redirect)                state_nxt = FETCH;
        else if (halt)               state_nxt = HALT;
        else if (count_nxt == QCAP)  state_nxt = FULL;
        else                         state_nxt = FETCH;
      end
      FULL: begin
        if (redirect)                state_nxt = FETCH;
        else if (halt)               state_nxt = HALT;
        else if (pop)                state_nxt = FETCH;
        else                         state_nxt = FULL;
      end
      HALT: begin
        if (redirect)                state_nxt = FETCH;
        else                         state_nxt = HALT;
      end
      default:                       state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      readM1      <= 1'b0;
      fpc         <= '0;
      count       <= 2'd0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      fetch_count <= '0;
      for (int i = 0; i < 2; i++) begin
        pc_mem[i]   <= '0;
        word_mem[i] <= '0;
      end
    end else begin
      state  <= state_nxt;
      readM1 <= (state_nxt == FETCH);
      count  <= count_nxt;
      if (pop) begin
        fetch_count <= fetch_count + WORD_SIZE'(1);
        rd_ptr      <= ~rd_ptr;
      end
      if (accept) begin
        pc_mem[wr_ptr]   <= fpc;
        word_mem[wr_ptr] <= data1;
        wr_ptr           <= ~wr_ptr;
        fpc              <= fpc + WORD_SIZE'(1);
      end
      if (redirect) begin
        fpc    <= redirect_pc;
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb/tb_inst_fetch_queue.sv - randomized and directed bench for inst_fetch_queue
module tb_inst_fetch_queue;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        readM1;
  logic [15:0] address1;
  logic [15:0] data1;
  logic        mem_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0;
  logic        halt = 1'b0;
  logic        id_stall = 1'b0;
  logic        inst_valid;
  logic [15:0] inst;
  logic [15:0] inst_pc;
  logic [15:0] fetch_count;

  int tests = 0;
  int fails = 0;

  // reference model: queue of {pc, word}, fetch pointer, delivered count
  logic [31:0] q[$];
  logic [15:0] m_fpc;
  logic [15:0] m_fc;
  bit          started;
  bit          halted;

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return (a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  assign data1 = mem_word(address1);

  inst_fetch_queue #(.WORD_SIZE(16), .DEPTH(2)) dut (
    .clk(clk), .reset_n(reset_n), .readM1(readM1), .address1(address1),
    .data1(data1), .mem_ready(mem_ready), .redirect(redirect),
    .redirect_pc(redirect_pc), .halt(halt), .id_stall(id_stall),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .fetch_count(fetch_count)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_fpc   = 16'h0;
    m_fc    = 16'h0;
    started = 1'b0;
    halted  = 1'b0;
  endtask

  task automatic check_model();
    logic        v;
    logic        rd;
    v  = (q.size() != 0);
    rd = started && !halted && (q.size() < 2);
    check("readM1", {15'h0, readM1}, {15'h0, rd});
    check("address1", address1, m_fpc);
    check("inst_valid", {15'h0, inst_valid}, {15'h0, v});
    check("inst", inst, v ? q[0][15:0] : 16'h0);
    check("inst_pc", inst_pc, v ? q[0][31:16] : 16'h0);
    check("fetch_count", fetch_count, m_fc);
  endtask

  task automatic model_edge();
    bit rd;
    bit pop;
    bit acc;
    rd  = started && !halted && (q.size() < 2);
    pop = (q.size() != 0) && !id_stall;
    acc = rd && mem_ready && !redirect;
    if (pop) begin
      void'(q.pop_front());
      m_fc++;
    end
    if (redirect) begin
      q.delete();
      m_fpc  = redirect_pc;
      halted = 1'b0;
    end else begin
      if (acc) begin
        q.push_back({m_fpc, mem_word(m_fpc)});
        m_fpc++;
      end
      if (started && halt) halted = 1'b1;
    end
    started = 1'b1;
  endtask

  task automatic cycle(input logic st, input logic mr, input logic rdr,
                       input logic [15:0] rpc, input logic hl);
    id_stall    = st;
    mem_ready   = mr;
    redirect    = rdr;
    redirect_pc = rpc;
    halt        = hl;
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_model();
  endtask

  // reset asserted mid-cycle; outputs must clear before any clock edge
  task automatic async_reset();
    #2 reset_n = 1'b0;
    #1;
    check("rst_readM1", {15'h0, readM1}, 16'h0);
    check("rst_address1", address1, 16'h0);
    check("rst_inst_valid", {15'h0, inst_valid}, 16'h0);
    check("rst_inst", inst, 16'h0);
    check("rst_inst_pc", inst_pc, 16'h0);
    check("rst_fetch_count", fetch_count, 16'h0);
    model_reset();
    id_stall = 1'b0; mem_ready = 1'b0; redirect = 1'b0; halt = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check_model();
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_model();
    reset_n = 1'b1;

    // streaming with memory always ready and decode never stalling
    for (int k = 1; k <= 6; k++) begin
      cycle(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
      check("stream_addr", address1, 16'(k - 1));
      if (k >= 2) check("stream_pc", inst_pc, 16'(k - 2));
    end
    check("stream_count", fetch_count, 16'd4);

    // decode stall fills the queue
    async_reset();
    for (int k = 0; k < 5; k++) cycle(1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
    check("full_readM1", {15'h0, readM1}, 16'h0);
    check("full_fpc", address1, 16'h2);
    check("full_head", inst_pc, 16'h0);
    cycle(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
    check("resume_head", inst_pc, 16'h1);
    check("resume_addr", address1, 16'h2);
    cycle(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
    check("resume_head2", inst_pc, 16'h2);

    // memory wait states hold the address
    cycle(1'b0, 1'b1, 1'b1, 16'h0005, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
      check("wait_addr", address1, 16'h0005);
      check("wait_empty", {15'h0, inst_valid}, 16'h0);
    end
    cycle(1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
    check("wait_pc", inst_pc, 16'h0005);

    // redirect with a full queue and a same-cycle response
    cycle(1'b1, 1'b1, 1'b1, 16'h0040, 1'b0);
    check("redir_empty", {15'h0, inst_valid}, 16'h0);
    check("redir_addr", address1, 16'h0040);
    cycle(1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
    check("redir_pc", inst_pc, 16'h0040);

    // halt with one entry queued
    cycle(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
    check("halt_readM1", {15'h0, readM1}, 16'h0);
    cycle(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
    check("halt_drain", fetch_count, m_fc);
    for (int k = 0; k < 4; k++) cycle(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
    check("halt_idle", {15'h0, readM1}, 16'h0);

    // fetch pointer wrap
    async_reset();
    cycle(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
    check("wrap_addr", address1, 16'h0000);
    check("wrap_pc", inst_pc, 16'hFFFF);

    // randomized traffic
    for (int k = 0; k < 600; k++) begin
      logic [15:0] rpc;
      rpc = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFE + $urandom_range(0, 1)) : 16'($urandom);
      cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 19) == 0), rpc, ($urandom_range(0, 99) == 0));
      if (k % 150 == 149) async_reset();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
